// File: rtl/jtkicker_obj_pkg.sv
// Shared types for the Konami-style object scanner: FSM states, field indices
// and the byte-lane lookup that maps each object field onto the 32-bit RAM word.
package jtkicker_obj_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ADDR,
    ST_WAIT,
    ST_TEST,
    ST_STALL,
    ST_PUSH,
    ST_NEXT,
    ST_DONE
  } scan_state_t;

  localparam int F_ATTR = 0;
  localparam int F_X    = 1;
  localparam int F_CODE = 2;
  localparam int F_Y    = 3;

  // FORDER packs one 2-bit lane per field as {y,code,x,attr}
  function automatic int lane_of(input logic [7:0] forder, input int field);
    return int'(forder[field*2 +: 2]);
  endfunction

endpackage

// File: rtl/jtkicker_objscan_fifo.sv
// Small first-word-fall-through FIFO with synchronous flush; the head word is
// visible on rdata whenever empty is low.
module jtkicker_objscan_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr_reg;
  logic [PW:0]  rd_ptr_reg;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop on the same edge frees the slot being written, so full does not block
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_reg[PW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jtkicker_objscan.sv
// Per-line object scanner: walks object RAM after hinit and queues objects that
// cover the next render line. Optional stats ports under JTKICKER_OBJSCAN_STATS_EN.
module jtkicker_objscan
  import jtkicker_obj_pkg::*;
#(
  parameter int         OBJMAX = 64,
  parameter int         OBJ_H  = 16,
  parameter int         HITMAX = 8,
  parameter logic [7:0] FORDER = 8'b00_10_11_01
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pxl_cen,
  input  logic                      hinit,
  input  logic [7:0]                vrender,
  input  logic                      flip,
  output logic [$clog2(OBJMAX)-1:0] ram_addr,
  input  logic [31:0]               ram_data,
  output logic                      hit_valid,
  input  logic                      hit_ready,
  output logic [7:0]                hit_code,
  output logic [7:0]                hit_attr,
  output logic [7:0]                hit_x,
  output logic [3:0]                hit_ysub,
`ifdef JTKICKER_OBJSCAN_STATS_EN
  output logic [5:0]                hit_cnt,
  output logic [7:0]                ovf_cnt,
`endif
  output logic                      line_done,
  output logic                      overflow
);

  localparam int AW     = $clog2(OBJMAX);
  localparam int CW     = $clog2(HITMAX + 1);
  localparam int L_ATTR = lane_of(FORDER, F_ATTR);
  localparam int L_X    = lane_of(FORDER, F_X);
  localparam int L_CODE = lane_of(FORDER, F_CODE);
  localparam int L_Y    = lane_of(FORDER, F_Y);
  localparam bit LANES_OK = (L_ATTR != L_X) && (L_ATTR != L_CODE) && (L_ATTR != L_Y) &&
                            (L_X != L_CODE) && (L_X != L_Y) && (L_CODE != L_Y);

  scan_state_t   state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW-1:0] ram_addr_reg, ram_addr_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          overflow_reg, overflow_next;
  logic [7:0]    code_reg, code_next;
  logic [7:0]    attr_reg, attr_next;
  logic [7:0]    x_reg, x_next;
  logic [3:0]    ysub_reg, ysub_next;

  logic          line_start;
  logic          last_hit;
  logic          fifo_push, fifo_flush, fifo_pop, fifo_full, fifo_empty;
  logic [27:0]   fifo_wdata, fifo_rdata;
  logic [7:0]    obj_y, obj_code, obj_attr, obj_x;
  logic [7:0]    vline, dy;
  logic          obj_hit;

  assign obj_y    = ram_data[L_Y*8 +: 8];
  assign obj_code = ram_data[L_CODE*8 +: 8];
  assign obj_attr = ram_data[L_ATTR*8 +: 8];
  assign obj_x    = ram_data[L_X*8 +: 8];

  // 8-bit modulo difference lets objects straddling line 255/0 wrap naturally
  assign vline   = flip ? ~vrender : vrender;
  assign dy      = vline - obj_y;
  assign obj_hit = (dy < 8'(OBJ_H));

  assign line_start = hinit && pxl_cen;
  assign last_hit   = (cnt_reg == CW'(HITMAX - 1));

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    ram_addr_next = ram_addr_reg;
    cnt_next      = cnt_reg;
    overflow_next = overflow_reg;
    code_next     = code_reg;
    attr_next     = attr_reg;
    x_next        = x_reg;
    ysub_next     = ysub_reg;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    case (state_reg)
      ST_IDLE: state_next = ST_IDLE;
      ST_FLUSH: begin
        fifo_flush    = 1'b1;
        overflow_next = 1'b0;
        idx_next      = '0;
        cnt_next      = '0;
        state_next    = ST_ADDR;
      end
      ST_ADDR: begin
        ram_addr_next = idx_reg;
        state_next    = ST_WAIT;
      end
      ST_WAIT: state_next = ST_TEST;
      ST_TEST: begin
        code_next = obj_code;
        attr_next = obj_attr;
        x_next    = obj_x;
        ysub_next = dy[3:0];
        if (!obj_hit)      state_next = ST_NEXT;
        else if (fifo_full) state_next = ST_STALL;
        else               state_next = ST_PUSH;
      end
      ST_STALL: if (!fifo_full || fifo_pop) state_next = ST_PUSH;
      ST_PUSH: begin
        fifo_push = 1'b1;
        cnt_next  = cnt_reg + 1'b1;
        if (last_hit) begin
          overflow_next = 1'b1;
          state_next    = ST_DONE;
        end else begin
          state_next = ST_NEXT;
        end
      end
      // NEXT also presents the following address, so a miss costs WAIT/TEST/NEXT
      ST_NEXT: begin
        if (idx_reg == AW'(OBJMAX - 1)) begin
          state_next = ST_DONE;
        end else begin
          idx_next      = idx_reg + 1'b1;
          ram_addr_next = idx_reg + 1'b1;
          state_next    = ST_WAIT;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // a new line always restarts the scan and drops whatever is queued
    if (line_start) begin
      fifo_flush = 1'b1;
      fifo_push  = 1'b0;
      state_next = ST_FLUSH;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      idx_reg      <= '0;
      ram_addr_reg <= '0;
      cnt_reg      <= '0;
      overflow_reg <= 1'b0;
      code_reg     <= '0;
      attr_reg     <= '0;
      x_reg        <= '0;
      ysub_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      ram_addr_reg <= ram_addr_next;
      cnt_reg      <= cnt_next;
      overflow_reg <= overflow_next;
      code_reg     <= code_next;
      attr_reg     <= attr_next;
      x_reg        <= x_next;
      ysub_reg     <= ysub_next;
    end
  end

  assign fifo_wdata = {code_reg, attr_reg, x_reg, ysub_reg};
  assign fifo_pop   = hit_valid && hit_ready;

  jtkicker_objscan_fifo #(
    .DEPTH (HITMAX),
    .W     (28)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (fifo_flush),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hit_valid = !fifo_empty;
  assign {hit_code, hit_attr, hit_x, hit_ysub} = fifo_empty ? 28'd0 : fifo_rdata;
  assign ram_addr  = ram_addr_reg;
  assign line_done = (state_reg == ST_DONE);
  assign overflow  = overflow_reg;

`ifdef JTKICKER_OBJSCAN_STATS_EN
  logic [5:0] hit_cnt_reg;
  logic [7:0] ovf_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_reg <= '0;
      ovf_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_DONE) hit_cnt_reg <= 6'(cnt_reg);
      if (state_reg == ST_PUSH && last_hit && !line_start && ovf_cnt_reg != 8'hFF)
        ovf_cnt_reg <= ovf_cnt_reg + 8'd1;
    end
  end

  assign hit_cnt = hit_cnt_reg;
  assign ovf_cnt = ovf_cnt_reg;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    assert (LANES_OK);
  end
`endif

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Directed bench for jtkicker_objscan; checks hit_cnt/ovf_cnt too when built
// with JTKICKER_OBJSCAN_STATS_EN.
module tb_jtkicker_objscan;

  logic        clk = 1'b0;
  logic        rst_n, pxl_cen, hinit, flip, hit_ready, f_ready;
  logic [7:0]  vrender;
  logic [5:0]  ram_addr, f_ram_addr;
  logic [31:0] ram_data, f_ram_data;
  logic        hit_valid, line_done, overflow;
  logic [7:0]  hit_code, hit_attr, hit_x;
  logic [3:0]  hit_ysub;
  logic        f_hit_valid, f_line_done, f_overflow;
  logic [7:0]  f_hit_code, f_hit_attr, f_hit_x;
  logic [3:0]  f_hit_ysub;
`ifdef JTKICKER_OBJSCAN_STATS_EN
  logic [5:0]  hit_cnt, f_hit_cnt;
  logic [7:0]  ovf_cnt, f_ovf_cnt;
`endif

  logic [31:0] mem   [64];
  logic [31:0] f_mem [64];
  logic [27:0] q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_data   <= mem[ram_addr];
    f_ram_data <= f_mem[f_ram_addr];
  end

  jtkicker_objscan u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .hinit     (hinit),
    .vrender   (vrender),
    .flip      (flip),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .hit_valid (hit_valid),
    .hit_ready (hit_ready),
    .hit_code  (hit_code),
    .hit_attr  (hit_attr),
    .hit_x     (hit_x),
    .hit_ysub  (hit_ysub),
`ifdef JTKICKER_OBJSCAN_STATS_EN
    .hit_cnt   (hit_cnt),
    .ovf_cnt   (ovf_cnt),
`endif
    .line_done (line_done),
    .overflow  (overflow)
  );

  jtkicker_objscan #(.FORDER(8'b11_10_01_00)) u_ford (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .hinit     (hinit),
    .vrender   (vrender),
    .flip      (flip),
    .ram_addr  (f_ram_addr),
    .ram_data  (f_ram_data),
    .hit_valid (f_hit_valid),
    .hit_ready (f_ready),
    .hit_code  (f_hit_code),
    .hit_attr  (f_hit_attr),
    .hit_x     (f_hit_x),
    .hit_ysub  (f_hit_ysub),
`ifdef JTKICKER_OBJSCAN_STATS_EN
    .hit_cnt   (f_hit_cnt),
    .ovf_cnt   (f_ovf_cnt),
`endif
    .line_done (f_line_done),
    .overflow  (f_overflow)
  );

  // default lanes: y=0, attr=1, code=2, x=3
  function automatic logic [31:0] pack_def(input logic [7:0] y, code, x, attr);
    return {x, code, attr, y};
  endfunction

  function automatic logic [31:0] pack_alt(input logic [7:0] y, code, x, attr);
    return {y, code, x, attr};
  endfunction

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) begin
      mem[i]   = pack_def(8'hC0, 8'h00, 8'h00, 8'h00);
      f_mem[i] = pack_alt(8'hC0, 8'h00, 8'h00, 8'h00);
    end
  endtask

  task automatic start_line(input logic [7:0] vr, input logic fl);
    @(negedge clk);
    vrender = vr;
    flip    = fl;
    hinit   = 1'b1;
    @(negedge clk);
    hinit   = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      if (hit_valid && hit_ready) begin
        q.push_back({hit_code, hit_attr, hit_x, hit_ysub});
        $display("hit code=%h attr=%h x=%h ysub=%h", hit_code, hit_attr, hit_x, hit_ysub);
      end
      @(negedge clk);
    end
  endtask

  task automatic collect(input int budget, output bit done, output int cycles);
    done   = 1'b0;
    cycles = 0;
    while (cycles < budget) begin
      if (hit_valid && hit_ready) begin
        q.push_back({hit_code, hit_attr, hit_x, hit_ysub});
        $display("hit code=%h attr=%h x=%h ysub=%h", hit_code, hit_attr, hit_x, hit_ysub);
      end
      if (line_done) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
      cycles++;
    end
    @(negedge clk);
    drain(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pxl_cen = 1'b1; hinit = 1'b0; flip = 1'b0;
    vrender = 8'h00; hit_ready = 1'b1; f_ready = 1'b1;
    clear_ram();
    repeat (2) @(negedge clk);
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL reset_hit_valid got %b want 0", hit_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", overflow); end
    checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done got %b want 0", line_done); end
    checks++; if (hit_code !== 8'h00) begin errors++; $display("FAIL reset_hit_code got %h want 00", hit_code); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL idle_ram_addr got %0d want 0", ram_addr); end
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL idle_hit_valid got %b want 0", hit_valid); end
    $display("reset and idle done");
  endtask

  task automatic test_single_hit();
    bit done; int cycles;
    clear_ram();
    mem[5] = pack_def(8'h40, 8'h12, 8'h80, 8'h3C);
    q.delete();
    start_line(8'h47, 1'b0);
    collect(300, done, cycles);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_line_done got %b want 1", done); end
    checks++; if (cycles > 256) begin errors++; $display("FAIL single_latency got %0d want <=256", cycles); end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", q.size()); end
    checks++; if (q[0] !== {8'h12, 8'h3C, 8'h80, 4'd7}) begin errors++; $display("FAIL single_entry got %h want %h", q[0], {8'h12, 8'h3C, 8'h80, 4'd7}); end
  endtask

  task automatic test_flip_wrap();
    bit done; int cycles;
    q.delete();
    start_line(8'hB8, 1'b1);
    collect(300, done, cycles);
    checks++; if (q.size() != 1) begin errors++; $display("FAIL flip_count got %0d want 1", q.size()); end
    checks++; if (q[0] !== {8'h12, 8'h3C, 8'h80, 4'd7}) begin errors++; $display("FAIL flip_entry got %h want %h", q[0], {8'h12, 8'h3C, 8'h80, 4'd7}); end
    clear_ram();
    mem[9] = pack_def(8'hFA, 8'h55, 8'h10, 8'h01);
    q.delete();
    start_line(8'h03, 1'b0);
    collect(300, done, cycles);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_line_done got %b want 1", done); end
    checks++; if (q.size() != 1) begin errors++; $display("FAIL wrap_count got %0d want 1", q.size()); end
    checks++; if (q[0] !== {8'h55, 8'h01, 8'h10, 4'd9}) begin errors++; $display("FAIL wrap_entry got %h want %h", q[0], {8'h55, 8'h01, 8'h10, 4'd9}); end
  endtask

  task automatic test_overflow();
    bit done; int cycles;
    logic [27:0] exp;
    clear_ram();
    for (int i = 0; i < 12; i++) mem[i] = pack_def(8'h20, 8'(8'h30 + i), 8'(i * 4), 8'(i));
    q.delete();
    hit_ready = 1'b0;
    start_line(8'h25, 1'b0);
    collect(300, done, cycles);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ovf_line_done got %b want 1", done); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (hit_valid !== 1'b1) begin errors++; $display("FAIL ovf_queued got %b want 1", hit_valid); end
    hit_ready = 1'b1;
    drain(12);
    checks++; if (q.size() != 8) begin errors++; $display("FAIL ovf_count got %0d want 8", q.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {8'(8'h30 + i), 8'(i), 8'(i * 4), 4'd5};
      checks++; if (q[i] !== exp) begin errors++; $display("FAIL ovf_entry%0d got %h want %h", i, q[i], exp); end
    end
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", hit_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_held got %b want 1", overflow); end
`ifdef JTKICKER_OBJSCAN_STATS_EN
    checks++; if (hit_cnt !== 6'd8) begin errors++; $display("FAIL stats_hit_cnt got %0d want 8", hit_cnt); end
    checks++; if (ovf_cnt !== 8'd1) begin errors++; $display("FAIL stats_ovf_cnt got %0d want 1", ovf_cnt); end
`endif
  endtask

  task automatic test_abort();
    bit done; int cycles; int n; int seen_done;
    clear_ram();
    for (int i = 0; i < 3; i++) mem[i] = pack_def(8'h20, 8'(8'h30 + i), 8'h00, 8'h00);
    mem[40] = pack_def(8'h20, 8'h48, 8'h00, 8'h00);
    q.delete();
    hit_ready = 1'b0;
    start_line(8'h25, 1'b0);
    n = 0; seen_done = 0;
    while (ram_addr != 6'd10 && n < 100) begin
      if (line_done) seen_done++;
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 100) begin errors++; $display("FAIL abort_reach_idx got %0d want 10", ram_addr); end
    checks++; if (hit_code !== 8'h30) begin errors++; $display("FAIL abort_head got %h want 30", hit_code); end
    hinit = 1'b1;
    @(negedge clk);
    hinit = 1'b0;
    checks++; if (hit_valid !== 1'b0) begin errors++; $display("FAIL abort_flush got %b want 0", hit_valid); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (ram_addr !== 6'd0) begin errors++; $display("FAIL abort_restart_idx got %0d want 0", ram_addr); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf_clear got %b want 0", overflow); end
    hit_ready = 1'b1;
    collect(300, done, cycles);
    checks++; if (seen_done != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", seen_done); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL abort_new_done got %b want 1", done); end
    checks++; if (q.size() != 4) begin errors++; $display("FAIL abort_count got %0d want 4", q.size()); end
    checks++; if (q[0][27:20] !== 8'h30 || q[3][27:20] !== 8'h48) begin errors++; $display("FAIL abort_order got %h,%h want 30,48", q[0][27:20], q[3][27:20]); end
  endtask

  task automatic test_field_order();
    int n; int hits; bit done;
    logic [27:0] got;
    clear_ram();
    f_mem[7] = pack_alt(8'h60, 8'hA5, 8'h3C, 8'h5A);
    got = '0; hits = 0; done = 1'b0;
    start_line(8'h6B, 1'b0);
    for (n = 0; n < 300 && !done; n++) begin
      if (f_hit_valid && f_ready) begin
        got = {f_hit_code, f_hit_attr, f_hit_x, f_hit_ysub};
        hits++;
        $display("forder hit code=%h attr=%h x=%h ysub=%h", f_hit_code, f_hit_attr, f_hit_x, f_hit_ysub);
      end
      if (f_line_done) done = 1'b1;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL forder_done got %b want 1", done); end
    checks++; if (hits != 1) begin errors++; $display("FAIL forder_count got %0d want 1", hits); end
    checks++; if (got !== {8'hA5, 8'h5A, 8'h3C, 4'hB}) begin errors++; $display("FAIL forder_entry got %h want %h", got, {8'hA5, 8'h5A, 8'h3C, 4'hB}); end
`ifdef JTKICKER_OBJSCAN_STATS_EN
    checks++; if (f_hit_cnt !== 6'd1) begin errors++; $display("FAIL forder_hit_cnt got %0d want 1", f_hit_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_flip_wrap();
    test_overflow();
    test_abort();
    test_field_order();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
